// File: rtl/draw_ammo_hud_if.sv
// VGA pixel stream bundle: raster position, sync/blank strobes and 12-bit colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_ammo_hud.sv
// Ammunition HUD overlay: bullet icons, reserve gauge and blinking RELOAD bar
// drawn over the incoming VGA stream with a fixed 2-cycle latency.
module draw_ammo_hud #(
  parameter int          HUD_X      = 32,
  parameter int          HUD_Y      = 720,
  parameter int          BULLET_W   = 8,
  parameter int          BULLET_H   = 20,
  parameter int          BULLET_GAP = 6,
  parameter int          MAG_SIZE   = 6,
  parameter int          GAUGE_H    = 4,
  parameter int          BAR_H      = 10,
  parameter int          BLINK_DIV  = 32_500_000,
  parameter logic [11:0] BULLET_RGB = 12'hFC0,
  parameter logic [11:0] GAUGE_RGB  = 12'hFFF,
  parameter logic [11:0] RELOAD_RGB = 12'hF00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_enable,
  input  logic [2:0] bullets_in_magazine,
  input  logic [5:0] bullets_left,
  input  logic       show_reload_char,
  vga_if.in          in,
  vga_if.out         out
);

  localparam int          BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [11:0] PITCH    = 12'(BULLET_W + BULLET_GAP);
  localparam logic [11:0] ICON_W   = 12'(BULLET_W);
  localparam logic [11:0] X0       = 12'(HUD_X);
  localparam logic [11:0] BAR_X1   = 12'(HUD_X + MAG_SIZE * (BULLET_W + BULLET_GAP));
  localparam logic [11:0] ICON_Y0  = 12'(HUD_Y);
  localparam logic [11:0] ICON_Y1  = 12'(HUD_Y + BULLET_H);
  localparam logic [11:0] GAUGE_Y0 = 12'(HUD_Y + BULLET_H + 4);
  localparam logic [11:0] GAUGE_Y1 = 12'(HUD_Y + BULLET_H + 4 + GAUGE_H);
  localparam logic [11:0] BAR_Y0   = 12'(HUD_Y - 4 - BAR_H);
  localparam logic [11:0] BAR_Y1   = 12'(HUD_Y - 4);
  localparam logic [2:0]  MAG_MAX  = 3'(MAG_SIZE);

  // Frame-latched ammo state, so one frame is drawn from one consistent snapshot.
  logic [2:0] mag_l;
  logic [5:0] left_l;
  logic       reload_l;
  logic       en_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_l    <= '0;
      left_l   <= '0;
      reload_l <= 1'b0;
      en_l     <= 1'b0;
    end else if (in.hcount == 11'd0 && in.vcount == 11'd0) begin
      mag_l    <= (bullets_in_magazine > MAG_MAX) ? MAG_MAX : bullets_in_magazine;
      left_l   <= bullets_left;
      reload_l <= show_reload_char;
      en_l     <= game_enable;
    end
  end

  // Blink timer follows the live request so the bar shows as soon as it is latched.
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (rst || !show_reload_char) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  logic [11:0] h;
  logic [11:0] v;
  logic [11:0] gauge_x1;
  logic [11:0] icon_x;
  logic        bullet_hit;
  logic        gauge_hit;
  logic        reload_hit;

  assign h        = {1'b0, in.hcount};
  assign v        = {1'b0, in.vcount};
  assign gauge_x1 = X0 + {5'd0, left_l, 1'b0};

  // Icon left edges advance by a constant pitch; the loop unrolls to fixed compares.
  always_comb begin
    bullet_hit = 1'b0;
    icon_x     = X0;
    for (int i = 0; i < MAG_SIZE; i++) begin
      if (mag_l > 3'(i) && h >= icon_x && h < icon_x + ICON_W)
        bullet_hit = 1'b1;
      icon_x = icon_x + PITCH;
    end
    bullet_hit = bullet_hit && (v >= ICON_Y0) && (v < ICON_Y1);
  end

  assign gauge_hit  = (h >= X0) && (h < gauge_x1) && (v >= GAUGE_Y0) && (v < GAUGE_Y1);
  assign reload_hit = reload_l && blink_phase &&
                      (h >= X0) && (h < BAR_X1) && (v >= BAR_Y0) && (v < BAR_Y1);

  // Stage 1: register the stream and the hit flags.
  logic [10:0] hcount_p1;
  logic [10:0] vcount_p1;
  logic        hsync_p1;
  logic        vsync_p1;
  logic        hblnk_p1;
  logic        vblnk_p1;
  logic [11:0] rgb_p1;
  logic        bullet_p1;
  logic        gauge_p1;
  logic        reload_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_p1 <= '0;
      vcount_p1 <= '0;
      hsync_p1  <= 1'b0;
      vsync_p1  <= 1'b0;
      hblnk_p1  <= 1'b0;
      vblnk_p1  <= 1'b0;
      rgb_p1    <= '0;
      bullet_p1 <= 1'b0;
      gauge_p1  <= 1'b0;
      reload_p1 <= 1'b0;
    end else begin
      hcount_p1 <= in.hcount;
      vcount_p1 <= in.vcount;
      hsync_p1  <= in.hsync;
      vsync_p1  <= in.vsync;
      hblnk_p1  <= in.hblnk;
      vblnk_p1  <= in.vblnk;
      rgb_p1    <= in.rgb;
      bullet_p1 <= bullet_hit;
      gauge_p1  <= gauge_hit;
      reload_p1 <= reload_hit;
    end
  end

  logic [11:0] rgb_mix;

  always_comb begin
    rgb_mix = rgb_p1;
    if (en_l && !hblnk_p1 && !vblnk_p1) begin
      if (reload_p1)      rgb_mix = RELOAD_RGB;
      else if (gauge_p1)  rgb_mix = GAUGE_RGB;
      else if (bullet_p1) rgb_mix = BULLET_RGB;
    end
  end

  // Stage 2: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= hcount_p1;
      out.vcount <= vcount_p1;
      out.hsync  <= hsync_p1;
      out.vsync  <= vsync_p1;
      out.hblnk  <= hblnk_p1;
      out.vblnk  <= vblnk_p1;
      out.rgb    <= rgb_mix;
    end
  end

endmodule

// File: tb/tb_draw_ammo_hud.sv
// Directed bench for draw_ammo_hud: vector table of single-pixel cases plus
// pass-through, mid-frame latch, blink and mid-frame reset sequences.
module tb_draw_ammo_hud;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_enable;
  logic [2:0] bullets_in_magazine;
  logic [5:0] bullets_left;
  logic       show_reload_char;

  vga_if vin ();
  vga_if vout ();

  draw_ammo_hud #(.BLINK_DIV(100)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .game_enable         (game_enable),
    .bullets_in_magazine (bullets_in_magazine),
    .bullets_left        (bullets_left),
    .show_reload_char    (show_reload_char),
    .in                  (vin),
    .out                 (vout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  mag;
    logic [5:0]  left;
    logic        rel;
    logic        en;
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [2:0] mag, logic [5:0] left, logic rel, logic en,
                              logic [10:0] h, logic [10:0] v, logic hb, logic vb,
                              logic [11:0] rgb, logic [11:0] exp);
    vec_t t;
    t.mag = mag; t.left = left; t.rel = rel; t.en = en;
    t.h = h; t.v = v; t.hb = hb; t.vb = vb; t.rgb = rgb; t.exp = exp;
    tbl.push_back(t);
  endfunction

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] pack_out();
    return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
  endfunction

  task automatic set_pix(input logic [10:0] h, input logic [10:0] v,
                         input logic hb, input logic vb, input logic [11:0] rgb);
    vin.hcount = h; vin.vcount = v; vin.hblnk = hb; vin.vblnk = vb;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.rgb = rgb;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    set_pix(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
    tick(1);
  endtask

  task automatic chk_pix(input string name, input logic [10:0] h, input logic [10:0] v,
                         input logic hb, input logic vb, input logic [11:0] rgb,
                         input logic [11:0] exp);
    set_pix(h, v, hb, vb, rgb);
    tick(2);
    check(name, {26'd0, vout.rgb}, {26'd0, exp});
  endtask

  logic [37:0] hist[0:199];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    game_enable = 1'b0;
    bullets_in_magazine = 3'd0;
    bullets_left = 6'd0;
    show_reload_char = 1'b0;
    set_pix(11'd5, 11'd5, 1'b0, 1'b0, 12'hABC);
    tick(3);
    check("reset_out", pack_out(), 38'd0);
    rst = 1'b0;

    // Pass-through with enable off: every field delayed by exactly 2 cycles.
    for (int j = 0; j < 200; j++) begin
      if (j >= 2) check($sformatf("passthru_%0d", j), pack_out(), hist[j-2]);
      vin.hcount = 11'($urandom_range(0, 1343));
      vin.vcount = 11'($urandom_range(0, 805));
      vin.hsync  = 1'($urandom);
      vin.vsync  = 1'($urandom);
      vin.hblnk  = 1'($urandom);
      vin.vblnk  = 1'($urandom);
      vin.rgb    = 12'($urandom);
      hist[j] = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb};
      tick(1);
    end

    //   mag   left  rel   en    h        v        hb    vb    rgb      expected
    add(3'd3, 6'd0, 1'b0, 1'b1, 11'd32,  11'd720, 1'b0, 1'b0, 12'h123, 12'hFC0);
    add(3'd3, 6'd0, 1'b0, 1'b1, 11'd46,  11'd720, 1'b0, 1'b0, 12'h123, 12'hFC0);
    add(3'd3, 6'd0, 1'b0, 1'b1, 11'd60,  11'd720, 1'b0, 1'b0, 12'h123, 12'hFC0);
    add(3'd3, 6'd0, 1'b0, 1'b1, 11'd74,  11'd720, 1'b0, 1'b0, 12'h124, 12'h124);
    add(3'd3, 6'd0, 1'b0, 1'b1, 11'd40,  11'd720, 1'b0, 1'b0, 12'h125, 12'h125);
    add(3'd3, 6'd0, 1'b0, 1'b1, 11'd31,  11'd720, 1'b0, 1'b0, 12'h126, 12'h126);
    add(3'd3, 6'd0, 1'b0, 1'b1, 11'd39,  11'd739, 1'b0, 1'b0, 12'h127, 12'hFC0);
    add(3'd3, 6'd0, 1'b0, 1'b1, 11'd32,  11'd740, 1'b0, 1'b0, 12'h128, 12'h128);
    add(3'd7, 6'd0, 1'b0, 1'b1, 11'd102, 11'd720, 1'b0, 1'b0, 12'h129, 12'hFC0);
    add(3'd7, 6'd0, 1'b0, 1'b1, 11'd116, 11'd720, 1'b0, 1'b0, 12'h12A, 12'h12A);
    add(3'd0, 6'd10, 1'b0, 1'b1, 11'd51, 11'd744, 1'b0, 1'b0, 12'h200, 12'hFFF);
    add(3'd0, 6'd10, 1'b0, 1'b1, 11'd52, 11'd744, 1'b0, 1'b0, 12'h201, 12'h201);
    add(3'd0, 6'd10, 1'b0, 1'b1, 11'd32, 11'd747, 1'b0, 1'b0, 12'h202, 12'hFFF);
    add(3'd0, 6'd10, 1'b0, 1'b1, 11'd32, 11'd748, 1'b0, 1'b0, 12'h203, 12'h203);
    add(3'd0, 6'd10, 1'b0, 1'b1, 11'd32, 11'd743, 1'b0, 1'b0, 12'h204, 12'h204);
    add(3'd0, 6'd0, 1'b0, 1'b1, 11'd32,  11'd744, 1'b0, 1'b0, 12'h205, 12'h205);
    add(3'd3, 6'd0, 1'b0, 1'b0, 11'd32,  11'd720, 1'b0, 1'b0, 12'h300, 12'h300);
    add(3'd3, 6'd0, 1'b0, 1'b1, 11'd32,  11'd720, 1'b1, 1'b0, 12'h301, 12'h301);
    add(3'd3, 6'd0, 1'b0, 1'b1, 11'd32,  11'd720, 1'b0, 1'b1, 12'h302, 12'h302);
    add(3'd0, 6'd0, 1'b1, 1'b1, 11'd32,  11'd706, 1'b0, 1'b0, 12'h400, 12'hF00);
    add(3'd0, 6'd0, 1'b1, 1'b1, 11'd32,  11'd715, 1'b0, 1'b0, 12'h401, 12'hF00);
    add(3'd0, 6'd0, 1'b1, 1'b1, 11'd32,  11'd716, 1'b0, 1'b0, 12'h402, 12'h402);
    add(3'd0, 6'd0, 1'b1, 1'b1, 11'd115, 11'd706, 1'b0, 1'b0, 12'h403, 12'hF00);
    add(3'd0, 6'd0, 1'b1, 1'b1, 11'd116, 11'd706, 1'b0, 1'b0, 12'h404, 12'h404);
    add(3'd0, 6'd0, 1'b1, 1'b1, 11'd32,  11'd705, 1'b0, 1'b0, 12'h405, 12'h405);
    add(3'd0, 6'd0, 1'b1, 1'b1, 11'd32,  11'd706, 1'b0, 1'b1, 12'h406, 12'h406);
    add(3'd0, 6'd0, 1'b0, 1'b1, 11'd32,  11'd706, 1'b0, 1'b0, 12'h407, 12'h407);

    foreach (tbl[k]) begin
      show_reload_char = 1'b0;
      tick(1);
      bullets_in_magazine = tbl[k].mag;
      bullets_left        = tbl[k].left;
      show_reload_char    = tbl[k].rel;
      game_enable         = tbl[k].en;
      frame_start();
      chk_pix($sformatf("vec_%0d", k), tbl[k].h, tbl[k].v, tbl[k].hb, tbl[k].vb,
              tbl[k].rgb, tbl[k].exp);
    end

    // Mid-frame ammo change is ignored until the next frame start.
    show_reload_char = 1'b0;
    game_enable = 1'b1;
    bullets_left = 6'd0;
    bullets_in_magazine = 3'd5;
    frame_start();
    chk_pix("midframe_before", 11'd88, 11'd720, 1'b0, 1'b0, 12'h555, 12'hFC0);
    bullets_in_magazine = 3'd1;
    chk_pix("midframe_v400", 11'd88, 11'd400, 1'b0, 1'b0, 12'h556, 12'h556);
    chk_pix("midframe_still5", 11'd88, 11'd720, 1'b0, 1'b0, 12'h557, 12'hFC0);
    frame_start();
    chk_pix("nextframe_icon5_gone", 11'd88, 11'd720, 1'b0, 1'b0, 12'h558, 12'h558);
    chk_pix("nextframe_icon0", 11'd32, 11'd720, 1'b0, 1'b0, 12'h559, 12'hFC0);

    // Blink with a 100-cycle half-period; edges counted from the frame-start edge.
    bullets_in_magazine = 3'd0;
    show_reload_char = 1'b0;
    tick(1);
    show_reload_char = 1'b1;
    frame_start();
    set_pix(11'd32, 11'd706, 1'b0, 1'b0, 12'h0A5);
    tick(49);
    check("blink_e50_on", {26'd0, vout.rgb}, {26'd0, 12'hF00});
    tick(70);
    check("blink_e120_off", {26'd0, vout.rgb}, {26'd0, 12'h0A5});
    tick(90);
    check("blink_e210_on", {26'd0, vout.rgb}, {26'd0, 12'hF00});
    tick(110);
    check("blink_e320_off", {26'd0, vout.rgb}, {26'd0, 12'h0A5});
    show_reload_char = 1'b0;
    tick(3);
    check("blink_deassert_phase1", {26'd0, vout.rgb}, {26'd0, 12'hF00});

    // Reset mid-frame: outputs clear at once, overlay stays off until next frame start.
    bullets_in_magazine = 3'd3;
    frame_start();
    chk_pix("prerst_icon", 11'd32, 11'd720, 1'b0, 1'b0, 12'h777, 12'hFC0);
    rst = 1'b1;
    tick(1);
    check("midrst_out_zero", pack_out(), 38'd0);
    rst = 1'b0;
    tick(2);
    check("postrst_passthru", {26'd0, vout.rgb}, {26'd0, 12'h777});
    frame_start();
    chk_pix("postrst_relatch", 11'd32, 11'd720, 1'b0, 1'b0, 12'h778, 12'hFC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
